apb_req_arbiter: RTL and testbench

- Single APB master that shares one APB slave port, such as the 48-bit temp register slave, between NUM_REQ local requesters.
- Arbitrates round-robin and registers the winner's command.
- Sequences the APB SETUP and ACCESS phases.
- Returns read data to the winner with a one-cycle done pulse.
- Sits between in-block command sources and the APB slave. The slave has no pready, so every ACCESS phase is exactly one cycle.

---
 rtl/apb_req_arbiter_if.sv | 30 +++
 rtl/apb_req_arbiter.sv | 143 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// Requester-side command bus and APB master bus shared by apb_req_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface apb_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic                      psel;
  logic                      pwrite;
  logic                      penable;
  logic [DATA_W-1:0]         prdata;

  modport master (
    input  req, req_addr, req_wdata, req_write, prdata,
    output done, rdata, paddr, pwdata, psel, pwrite, penable
  );

  modport slave (
    output req, req_addr, req_wdata, req_write, prdata,
    input  done, rdata, paddr, pwdata, psel, pwrite, penable
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB slave (no pready) between NUM_REQ requesters.
// Each transfer walks IDLE -> SETUP -> ACCESS -> DONE; all outputs are registered.
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              pclk,
  input  logic              preset,
  apb_req_arbiter_if.master bus
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  done_q, done_d;

  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_write;

  // Search starts one past the last grant so every requester gets its turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % NUM_REQ);
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        win_write = bus.req_write[i];
      end
    end
  end

  // Next-state and next-output logic; APB strobes are set for the state being entered.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    rdata_d   = rdata_q;
    done_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d  = S_SETUP;
          gnt_d    = win_idx;
          paddr_d  = win_addr;
          pwdata_d = win_wdata;
          pwrite_d = win_write;
          psel_d   = 1'b1;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        state_d       = S_DONE;
        done_d[gnt_q] = 1'b1;
        if (!pwrite_q) begin
          rdata_d = bus.prdata;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = gnt_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      last_q    <= LAST_RST;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
    end
  end

  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.psel    = psel_q;
  assign bus.penable = penable_q;
  assign bus.rdata   = rdata_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a transfer-level reference model and a small APB slave.
module tb_apb_req_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic pclk;
  logic preset;

  apb_req_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Slave: 16 word registers; the one at 0x4 only implements its low 16 bits.
  logic [31:0] slv_mem [0:15];
  initial for (int i = 0; i < 16; i++) slv_mem[i] = 32'h0;

  function automatic logic [31:0] slv_view(input logic [31:0] a, input logic [31:0] d);
    return (a == 32'h4) ? (d & 32'h0000_FFFF) : d;
  endfunction

  always @(posedge pclk)
    if (bus.psel && bus.penable && bus.pwrite) slv_mem[bus.paddr[5:2]] <= bus.pwdata;

  assign bus.prdata = (bus.psel && bus.penable && !bus.pwrite)
                      ? slv_view(bus.paddr, slv_mem[bus.paddr[5:2]]) : 32'hBAD0_BAD0;

  // Reference model: a transfer is a 4-cycle event whose age selects the expected bus view.
  int          m_age  = 0;
  int          m_gnt  = 0;
  int          m_last = NR - 1;
  int          m_cyc  = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic        m_write = 1'b0;
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? slv_view(a, ref_mem[a]) : 32'h0;
  endfunction

  always @(posedge pclk) begin
    m_cyc++;
    if (m_age == 2 && m_write) ref_mem[m_addr] = m_wdata;
    if (preset) begin
      m_age = 0; m_last = NR - 1; m_addr = '0; m_wdata = '0; m_write = 1'b0; m_rdata = '0;
    end else if (m_age == 0) begin
      for (int k = NR; k >= 1; k--)
        if (bus.req[(m_last + k) % NR]) m_gnt = (m_last + k) % NR;
      if (bus.req != '0) begin
        m_age   = 1;
        m_addr  = bus.req_addr[m_gnt*AW +: AW];
        m_wdata = bus.req_wdata[m_gnt*DW +: DW];
        m_write = bus.req_write[m_gnt];
      end
    end else if (m_age == 2) begin
      if (!m_write) m_rdata = ref_rd(m_addr);
      m_age = 3;
    end else if (m_age == 3) begin
      m_last = m_gnt;
      m_age  = 0;
    end else begin
      m_age++;
    end
  end

  task automatic model_cmp();
    logic          e_psel, e_pen;
    logic [NR-1:0] e_done;
    e_psel = (m_age == 1) || (m_age == 2);
    e_pen  = (m_age == 2);
    e_done = (m_age == 3) ? NR'(1 << m_gnt) : '0;
    n_cmp++;
    if (bus.psel !== e_psel || bus.penable !== e_pen || bus.done !== e_done ||
        bus.rdata !== m_rdata || bus.paddr !== m_addr || bus.pwdata !== m_wdata ||
        bus.pwrite !== m_write) begin
      n_err++;
      $display("FAIL model cyc=%0d got psel=%b pen=%b done=%b rdata=%h paddr=%h pwdata=%h pwrite=%b exp psel=%b pen=%b done=%b rdata=%h paddr=%h pwdata=%h pwrite=%b",
               m_cyc, bus.psel, bus.penable, bus.done, bus.rdata, bus.paddr, bus.pwdata, bus.pwrite,
               e_psel, e_pen, e_done, m_rdata, m_addr, m_wdata, m_write);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
    if (chk_en) model_cmp();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic w);
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
    bus.req_write[i]          = w;
    bus.req[i]                = 1'b1;
  endtask

  task automatic clr_req(input int i);
    bus.req[i] = 1'b0;
  endtask

  task automatic wait_any(input string name, input int budget, output int idx);
    bit ok;
    ok  = 1'b0;
    idx = -1;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      for (int i = 0; i < NR; i++)
        if (bus.done[i]) begin ok = 1'b1; idx = i; end
    end
    check({name, " done_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic xfer(input string name, input int i, input logic [31:0] a,
                      input logic [31:0] d, input logic w);
    int idx;
    set_req(i, a, d, w);
    wait_any(name, 8, idx);
    check({name, " gnt"}, 64'(idx), 64'(i));
    clr_req(i);
    tick();
  endtask

  int idx, prev_cyc;

  initial begin
    preset        = 1'b1;
    bus.req       = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_write = '0;

    // Reset held for two edges, then idle with no requests.
    @(negedge pclk);
    chk_en = 1'b1;
    tick();
    check("rst psel", 64'(bus.psel), 64'd0);
    check("rst penable", 64'(bus.penable), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst rdata", 64'(bus.rdata), 64'd0);
    preset = 1'b0;
    repeat (3) tick();
    check("idle psel", 64'(bus.psel), 64'd0);

    // Single write, edge by edge, then read it back.
    set_req(0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    tick();
    check("wr setup psel/pen", 64'({bus.psel, bus.penable}), 64'b10);
    tick();
    check("wr access psel/pen", 64'({bus.psel, bus.penable}), 64'b11);
    check("wr access pwdata", 64'(bus.pwdata), 64'hDEAD_BEEF);
    tick();
    check("wr done", 64'(bus.done), 64'b01);
    clr_req(0);
    tick();
    check("wr idle psel", 64'(bus.psel), 64'd0);
    check("wr idle paddr kept", 64'(bus.paddr), 64'h0);
    set_req(0, 32'h0, 32'h0, 1'b0);
    repeat (3) tick();
    check("rd done", 64'(bus.done), 64'b01);
    check("rd rdata", 64'(bus.rdata), 64'hDEAD_BEEF);
    clr_req(0);
    tick();

    // Prime last grant to requester 1, then hold both requesters continuously.
    xfer("t3 prime", 1, 32'h0, 32'h0, 1'b0);
    set_req(0, 32'h4, 32'h0001_2345, 1'b1);
    set_req(1, 32'h4, 32'h0, 1'b0);
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any("t3 rr", 8, idx);
      check("t3 grant order", 64'(idx), 64'(k % 2));
      if (k > 0) check("t3 spacing", 64'(m_cyc - prev_cyc), 64'd4);
      if (k % 2 == 1) check("t3 masked rdata", 64'(bus.rdata), 64'h0000_2345);
      prev_cyc = m_cyc;
    end
    clr_req(0);
    clr_req(1);
    tick();

    // Late request during ACCESS is not granted until the next IDLE.
    set_req(0, 32'h8, 32'hA5A5_A5A5, 1'b1);
    tick();
    check("t4 setup paddr", 64'(bus.paddr), 64'h8);
    tick();
    check("t4 access pen", 64'(bus.penable), 64'd1);
    set_req(1, 32'h8, 32'h0, 1'b0);
    tick();
    check("t4 done req0 only", 64'(bus.done), 64'b01);
    clr_req(0);
    tick();
    check("t4 idle psel", 64'(bus.psel), 64'd0);
    check("t4 idle paddr kept", 64'(bus.paddr), 64'h8);
    tick();
    check("t4 late setup", 64'({bus.psel, bus.penable, bus.pwrite}), 64'b100);
    wait_any("t4 late", 8, idx);
    check("t4 late gnt", 64'(idx), 64'd1);
    check("t4 late rdata", 64'(bus.rdata), 64'hA5A5_A5A5);
    clr_req(1);
    tick();

    // Reset during ACCESS aborts the transfer; requester 0 wins first afterwards.
    set_req(0, 32'hC, 32'h1111_1111, 1'b1);
    repeat (2) tick();
    check("t5 access pen", 64'(bus.penable), 64'd1);
    preset = 1'b1;
    set_req(1, 32'h0, 32'h0, 1'b0);
    tick();
    check("t5 rst psel/pen", 64'({bus.psel, bus.penable}), 64'b00);
    check("t5 rst done", 64'(bus.done), 64'd0);
    preset = 1'b0;
    wait_any("t5 after rst", 8, idx);
    check("t5 first gnt", 64'(idx), 64'd0);
    clr_req(0);
    wait_any("t5 second", 8, idx);
    check("t5 second gnt", 64'(idx), 64'd1);
    check("t5 rdata", 64'(bus.rdata), 64'hDEAD_BEEF);
    clr_req(1);
    tick();

    // A write leaves rdata untouched.
    xfer("t6 wr1", 0, 32'h10, 32'h1234_5678, 1'b1);
    xfer("t6 rd1", 0, 32'h10, 32'h0, 1'b0);
    check("t6 rdata", 64'(bus.rdata), 64'h1234_5678);
    xfer("t6 wr2", 0, 32'h10, 32'hFFFF_FFFF, 1'b1);
    repeat (2) tick();
    check("t6 rdata kept", 64'(bus.rdata), 64'h1234_5678);
    xfer("t6 rd2", 0, 32'h10, 32'h0, 1'b0);
    check("t6 rdata new", 64'(bus.rdata), 64'hFFFF_FFFF);
    check("t6 model pin", 64'(m_rdata), 64'hFFFF_FFFF);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
